// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result capture path.
package fft_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned WORD_W = 32;

   // Capture state encoding, also visible to the register map.
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RECV  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   typedef enum logic [1:0] {
      StIdle  = IDLE,
      StRecv  = RECV,
      StDrain = DRAIN,
      StDone  = DONE
   } cap_state_e;

endpackage

// File: rtl/fft_output_capture_if.sv
// AXI-Stream link from the FFT core result port into the capture engine.
interface fft_output_capture_if;
   import fft_pkg::*;

   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [DATA_W-1:0] tdata;

   modport master (output tvalid, output tlast, output tdata, input tready);
   modport slave  (input tvalid, input tlast, input tdata, output tready);

endinterface

// File: rtl/fft_sample_ram.sv
// NFFT x 64 sample buffer: one write port, one registered 32-bit read port.
module fft_sample_ram
   import fft_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned SW    = $clog2(DEPTH),
   localparam int unsigned RW    = $clog2(DEPTH * 2)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              wr_en,
   input  logic [SW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [RW-1:0]     rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_sample;

   assign rd_sample = mem[rd_addr[RW-1:1]];

   // Sample write; storage is not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read of one word half; a same-cycle write is seen next time (old data wins).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= rd_addr[0] ? rd_sample[DATA_W-1:WORD_W] : rd_sample[WORD_W-1:0];
      end
   end

endmodule

// File: rtl/fft_output_capture.sv
// Captures one NFFT-sample frame from the FFT core stream, checks tlast framing,
// and exposes the buffer as 32-bit words on a registered read port.
module fft_output_capture
   import fft_pkg::*;
#(
   parameter  int unsigned NFFT = 8,
   localparam int unsigned AW   = $clog2(NFFT * 2)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                arm,
   input  logic                abort,
   input  logic                rEn,
   input  logic [AW-1:0]       rAddr,
   output logic [WORD_W-1:0]   rData,
   output logic                rValid,
   fft_output_capture_if.slave s_axis,
   output logic                receiving,
   output logic                done,
   output logic                err_short,
   output logic                err_long,
   output logic [15:0]         frame_count
);

   localparam int unsigned    CW       = $clog2(NFFT);
   localparam logic [CW-1:0]  LAST_IDX = CW'(NFFT - 1);

   cap_state_e    state;
   logic [CW-1:0] cnt;
   logic          beat;
   logic          wr_en;

   // Abort masks ready so a beat offered in the abort cycle is never taken.
   assign s_axis.tready = receiving && !abort;
   assign beat          = s_axis.tvalid && s_axis.tready;
   assign wr_en         = beat && (state == StRecv);

   // Capture FSM with beat counter, sticky flags and frame counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= StIdle;
         cnt         <= '0;
         receiving   <= 1'b0;
         done        <= 1'b0;
         err_short   <= 1'b0;
         err_long    <= 1'b0;
         frame_count <= '0;
      end else begin
         case (state)
            StIdle, StDone: begin
               // Abort has priority over arm, even where abort alone does nothing.
               if (arm && !abort) begin
                  state     <= StRecv;
                  receiving <= 1'b1;
                  cnt       <= '0;
                  done      <= 1'b0;
                  err_short <= 1'b0;
                  err_long  <= 1'b0;
               end
            end
            StRecv: begin
               if (abort) begin
                  state     <= StIdle;
                  receiving <= 1'b0;
               end else if (beat) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_IDX) begin
                     if (s_axis.tlast) begin
                        state       <= StDone;
                        receiving   <= 1'b0;
                        done        <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                     end else begin
                        state    <= StDrain;
                        err_long <= 1'b1;
                     end
                  end else if (s_axis.tlast) begin
                     state     <= StDone;
                     receiving <= 1'b0;
                     done      <= 1'b1;
                     err_short <= 1'b1;
                  end
               end
            end
            StDrain: begin
               if (abort) begin
                  state     <= StIdle;
                  receiving <= 1'b0;
               end else if (beat && s_axis.tlast) begin
                  state     <= StDone;
                  receiving <= 1'b0;
                  done      <= 1'b1;
               end
            end
            default: begin
               state     <= StIdle;
               receiving <= 1'b0;
            end
         endcase
      end
   end

   // One valid pulse per read strobe, aligned with the registered RAM output.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rValid <= 1'b0;
      end else begin
         rValid <= rEn;
      end
   end

   fft_sample_ram #(
      .DEPTH(NFFT)
   ) u_ram (
      .clk    (clk),
      .resetn (resetn),
      .wr_en  (wr_en),
      .wr_addr(cnt),
      .wr_data(s_axis.tdata),
      .rd_en  (rEn),
      .rd_addr(rAddr),
      .rd_data(rData)
   );

endmodule
